// File: rtl/pipe_pkg.sv
// Shared types for the pipe_stage_reg skid-buffered pipeline register.
// Perf counters are enabled by defining PIPE_STAGE_PERF_EN.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int PERF_W_DEF = 16;

endpackage

// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle between upstream, stage and downstream.
// Perf counters are enabled by defining PIPE_STAGE_PERF_EN.
interface pipe_stage_if #(
  parameter int DATA_W = 32
) ();

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;

  modport master (
    input  in_valid_i,
    input  in_data_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o
  );

  modport slave (
    output in_valid_i,
    output in_data_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o
  );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
// Only instantiated when PIPE_STAGE_PERF_EN is defined.
module pipe_perf_cnt
  import pipe_pkg::*;
#(
  parameter int PERF_W = PERF_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [PERF_W-1:0] cnt_o
);

  logic [PERF_W-1:0] cnt_d;
  logic [PERF_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register with flush and optional perf counters.
// Perf counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ZERO_ON_FLUSH = 1,
  parameter int PERF_W        = PERF_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  pipe_stage_if.master      bus,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  state_e            state_d, state_q;
  logic [DATA_W-1:0] main_d, main_q;
  logic [DATA_W-1:0] skid_d, skid_q;
  logic              in_ready_d, in_ready_q;
  logic              out_valid_d, out_valid_q;
  logic              accept;
  logic              emit;

  assign accept = bus.in_valid_i & in_ready_q;
  assign emit   = out_valid_q & bus.out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      if (ZERO_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = bus.in_data_i;
          end
        end
        ONE: begin
          unique case (1'b1)
            (accept && emit): main_d = bus.in_data_i;
            (accept && !emit): begin
              state_d = TWO;
              skid_d  = bus.in_data_i;
            end
            (!accept && emit): state_d = EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (emit) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Handshake flags are registered copies of the next-state decode
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = main_q;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = out_valid_q & ~bus.out_ready_i;
  assign flush_inc = flush_i & out_valid_q;

  pipe_perf_cnt #(
    .PERF_W(PERF_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .inc_i  (stall_inc),
    .clr_i  (1'b0),
    .cnt_o  (stall_cnt_o)
  );

  pipe_perf_cnt #(
    .PERF_W(PERF_W)
  ) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .inc_i  (flush_inc),
    .clr_i  (1'b0),
    .cnt_o  (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
